ledwalk_ctrl: RTL and testbench
===============================

// Module: ledwalk_ctrl
// PURPOSE
//  Command-driven controller for the 8-bit LED walker bank. Accepts start/stop/pause/rate
//  commands over a valid/ready port and owns the step prescaler. Sequences the LED index
//  in one of three walk modes. Sits between a host/debug command source and the board LEDs.
// PARAMETERS
//  BASE_DIV    1_200_000  clocks per rate unit (0.1 s @ 12 MHz); must be >= 1
//  RATE_RST    8'd9       step-period multiplier after reset (period = (RATE+1)*BASE_DIV clocks)
//  CNT_W       32         prescaler counter width; must hold 256*BASE_DIV-1
// PORTS
//  i_clk        in   1  system clock
//  i_reset      in   1  synchronous, active-high reset
//  i_cmd_valid  in   1  command valid
//  o_cmd_ready  out  1  command ready; transfer when i_cmd_valid && o_cmd_ready
//  i_cmd_op     in   2  00 STOP, 01 START, 10 PAUSE (toggle), 11 SET_RATE
//  i_cmd_arg    in   8  START: arg[1:0]=mode; SET_RATE: new RATE; else ignored
//  o_led        out  8  LED drive, one-hot while running/paused, 0 in IDLE
//  o_busy       out  1  1 in RUN or PAUSED
//  o_state      out  2  00 IDLE, 01 RUN, 10 PAUSED
// BEHAVIOUR
//  Reset: o_led=0, o_busy=0, o_state=IDLE, o_cmd_ready=0 while i_reset high, 1 the cycle after;
//   idx=0, mode=BOUNCE, rate=RATE_RST, prescaler=0. Reset mid-walk aborts immediately.
//  o_cmd_ready is 1 in every state outside reset; all outputs registered.
//  Modes (arg[1:0]): 00 BOUNCE idx 0..13 then 0 (LED 0->7->1, 14 steps, as LED pattern
//   01,02,04..80,40..02); 01 WRAP idx 0..7 then 0 (01->80->01); 10 ONESHOT idx 0..7 then
//   IDLE on the step after 80; 11 reserved, decoded as BOUNCE.
//  Prescaler: on START load cnt=(rate+1)*BASE_DIV-1; in RUN decrement; cnt==0 -> tick, reload
//   from current rate. PAUSED freezes cnt and idx. SET_RATE updates rate only; no reload, so
//   new period applies from the next reload (current period completes unchanged).
//  Tick in RUN: advance idx per mode; o_led updates the cycle after tick.
//  FSM:
//   IDLE   --START-->  RUN (idx=0, o_led=01 next cycle, mode latched, cnt loaded)
//   IDLE   --STOP/PAUSE--> no effect; SET_RATE accepted in any state
//   RUN    --START-->  RUN restarted: idx=0, new mode, cnt reloaded
//   RUN    --PAUSE-->  PAUSED;  --STOP--> IDLE, o_led=0 next cycle
//   RUN    --ONESHOT tick at idx 7--> IDLE, o_led=0
//   PAUSED --PAUSE-->  RUN (resume, cnt/idx intact);  --START--> RUN restart;  --STOP--> IDLE
//  Accepted command and tick in same cycle: command wins, tick discarded (no idx advance).
//  Rate product computed at CNT_W bits; RATE=0 gives period BASE_DIV.
// CONFIGURATION
//  LEDWALK_DONE_IRQ_EN defined: extra output o_done (1 bit, reset 0), single-cycle pulse the
//   cycle after a walk completes a full pass (BOUNCE idx 13->0, WRAP idx 7->0, ONESHOT
//   finish -> IDLE). STOP/restart never pulse it.
//  Not defined: no o_done port, no completion logic; behaviour otherwise identical.
// TESTING (BASE_DIV=2, RATE_RST=1 -> 4-clock period)
//  Reset: hold i_reset 3 cycles -> o_led=0, o_state=00, o_cmd_ready=0 then 1 after release.
//  START arg=00 -> o_led 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01 each 4 clocks apart.
//  START arg=10 -> 01..80 then o_led=0, o_state=00, o_busy=0; with _EN, o_done=1 for 1 cycle.
//  PAUSE at o_led=08 for 20 clocks, PAUSE again -> 08 held, next 10 exactly 4-cnt_remaining later.
//  SET_RATE arg=3 mid-period -> current step still 4 clocks, following steps 8 clocks.
//  START coincident with tick while at 20 -> o_led=01 next cycle, no 40; STOP -> o_led=0 next.

Source files
------------

// File: rtl/ledwalk_ctrl.sv
// ledwalk_ctrl: command-driven 8-bit LED walker with prescaled step timing.
// Optional LEDWALK_DONE_IRQ_EN adds o_done, a one-cycle pulse at the end of each full pass.
module ledwalk_ctrl #(
  parameter int BASE_DIV = 1_200_000,
  parameter logic [7:0] RATE_RST = 8'd9,
  parameter int CNT_W = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_arg,
  output logic [7:0] o_led,
  output logic       o_busy,
`ifdef LEDWALK_DONE_IRQ_EN
  output logic       o_done,
`endif
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10} state_t;
  localparam logic [1:0] OP_STOP = 2'b00, OP_START = 2'b01, OP_PAUSE = 2'b10, OP_RATE = 2'b11;
  localparam logic [1:0] M_WRAP = 2'b01, M_ONESHOT = 2'b10;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] idx_q, idx_d, led_pos;
  logic [7:0] rate_q, rate_d, led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, reload;
  logic ready_q, busy_q, accept, cmd_win, tick, pass_end;
  assign accept = i_cmd_valid && ready_q;
  assign cmd_win = accept && i_cmd_op != OP_RATE;
  assign tick = state_q == S_RUN && cnt_q == '0;
  assign reload = (CNT_W'(rate_q) + CNT_W'(1)) * CNT_W'(BASE_DIV) - CNT_W'(1);
  // last index of a pass: 7 for WRAP/ONESHOT, 13 for BOUNCE and the reserved mode
  assign pass_end = tick && !cmd_win &&
                    (mode_q == M_WRAP || mode_q == M_ONESHOT ? idx_q == 4'd7 : idx_q == 4'd13);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    idx_d = idx_q;
    rate_d = rate_q;
    cnt_d = cnt_q;
    if (state_q == S_RUN) begin
      cnt_d = tick ? reload : cnt_q - CNT_W'(1);
      idx_d = pass_end ? 4'd0 : tick ? idx_q + 4'd1 : idx_q;
      state_d = pass_end && mode_q == M_ONESHOT ? S_IDLE : S_RUN;
    end
    if (accept) begin
      unique case (i_cmd_op)
        OP_STOP: begin
          state_d = S_IDLE;
          idx_d = 4'd0;
          cnt_d = cnt_q;
        end
        OP_START: begin
          state_d = S_RUN;
          idx_d = 4'd0;
          mode_d = i_cmd_arg[1:0];
          cnt_d = reload;
        end
        OP_PAUSE: begin
          state_d = state_q == S_RUN ? S_PAUSED : state_q == S_PAUSED ? S_RUN : S_IDLE;
          idx_d = idx_q;
          cnt_d = cnt_q;
        end
        OP_RATE: rate_d = i_cmd_arg;
      endcase
    end
    led_pos = idx_d < 4'd8 ? idx_d : 4'd14 - idx_d;
    led_d = state_d == S_IDLE ? 8'd0 : 8'd1 << led_pos[2:0];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mode_q <= 2'b00;
      idx_q <= 4'd0;
      rate_q <= RATE_RST;
      cnt_q <= '0;
      led_q <= 8'd0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      rate_q <= rate_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      ready_q <= 1'b1;
      busy_q <= state_d != S_IDLE;
    end
  end
`ifdef LEDWALK_DONE_IRQ_EN
  logic done_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) done_q <= 1'b0;
    else done_q <= pass_end;
  end
  assign o_done = done_q;
`endif
  assign o_cmd_ready = ready_q;
  assign o_led = led_q;
  assign o_busy = busy_q;
  assign o_state = state_q;
endmodule

// File: tb/tb_ledwalk_ctrl.sv
// tb_ledwalk_ctrl: directed test of ledwalk_ctrl with BASE_DIV=2, RATE_RST=1 (4-clock steps).
module tb_ledwalk_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'd0;
  logic [7:0] led;
  logic busy;
  logic [1:0] state;
`ifdef LEDWALK_DONE_IRQ_EN
  logic done;
`endif
  int pass_n = 0;
  int total_n = 0;
  logic [7:0] bounce [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] prev;
  always #5 clk = ~clk;
  ledwalk_ctrl #(.BASE_DIV(2), .RATE_RST(8'd1), .CNT_W(32)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op),
    .i_cmd_arg(cmd_arg),
    .o_led(led),
    .o_busy(busy),
`ifdef LEDWALK_DONE_IRQ_EN
    .o_done(done),
`endif
    .o_state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic step(input string tag, input logic [7:0] exp);
    wait_n(3);
    chk({tag, " hold"}, {24'd0, led}, {24'd0, prev});
    wait_n(1);
    chk(tag, {24'd0, led}, {24'd0, exp});
    prev = exp;
  endtask
  initial begin
    wait_n(3);
    chk("rst led", {24'd0, led}, 32'h0);
    chk("rst state", {30'd0, state}, 32'h0);
    chk("rst ready", {31'd0, cmd_ready}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    wait_n(1);
    chk("ready after rst", {31'd0, cmd_ready}, 32'h1);
    send(2'b10, 8'd0);
    chk("pause idle noop", {30'd0, state}, 32'h0);
    send(2'b01, 8'h00);
    chk("bounce start led", {24'd0, led}, 32'h01);
    chk("bounce state", {30'd0, state}, 32'h1);
    chk("bounce busy", {31'd0, busy}, 32'h1);
    prev = 8'h01;
    for (int i = 0; i < 14; i++) step($sformatf("bounce %0d", i), bounce[i]);
    send(2'b00, 8'd0);
    chk("stop led", {24'd0, led}, 32'h0);
    chk("stop state", {30'd0, state}, 32'h0);
    chk("stop busy", {31'd0, busy}, 32'h0);
    send(2'b01, 8'h02);
    chk("oneshot start", {24'd0, led}, 32'h01);
    prev = 8'h01;
    for (int i = 1; i < 8; i++) step($sformatf("oneshot %0d", i), 8'(1 << i));
    wait_n(4);
    chk("oneshot end led", {24'd0, led}, 32'h0);
    chk("oneshot end state", {30'd0, state}, 32'h0);
    chk("oneshot end busy", {31'd0, busy}, 32'h0);
`ifdef LEDWALK_DONE_IRQ_EN
    chk("oneshot done", {31'd0, done}, 32'h1);
    wait_n(1);
    chk("oneshot done clr", {31'd0, done}, 32'h0);
`endif
    send(2'b01, 8'h01);
    chk("wrap start", {24'd0, led}, 32'h01);
    prev = 8'h01;
    for (int i = 1; i < 8; i++) step($sformatf("wrap %0d", i), 8'(1 << i));
    step("wrap back", 8'h01);
    chk("wrap still run", {30'd0, state}, 32'h1);
`ifdef LEDWALK_DONE_IRQ_EN
    chk("wrap done", {31'd0, done}, 32'h1);
`endif
    send(2'b01, 8'h00);
    chk("restart led", {24'd0, led}, 32'h01);
    prev = 8'h01;
    step("p 02", 8'h02);
    step("p 04", 8'h04);
    step("p 08", 8'h08);
    wait_n(1);
    send(2'b10, 8'd0);
    chk("paused state", {30'd0, state}, 32'h2);
    chk("paused busy", {31'd0, busy}, 32'h1);
    wait_n(20);
    chk("paused led", {24'd0, led}, 32'h08);
    send(2'b10, 8'd0);
    chk("resume state", {30'd0, state}, 32'h1);
    wait_n(2);
    chk("resume hold", {24'd0, led}, 32'h08);
    wait_n(1);
    chk("resume step", {24'd0, led}, 32'h10);
    wait_n(1);
    send(2'b11, 8'd3);
    wait_n(1);
    chk("rate cur hold", {24'd0, led}, 32'h10);
    wait_n(1);
    chk("rate cur step", {24'd0, led}, 32'h20);
    wait_n(7);
    chk("rate new hold", {24'd0, led}, 32'h20);
    send(2'b01, 8'h00);
    chk("start on tick", {24'd0, led}, 32'h01);
    wait_n(7);
    chk("slow hold", {24'd0, led}, 32'h01);
    wait_n(1);
    chk("slow step", {24'd0, led}, 32'h02);
    send(2'b00, 8'd0);
    chk("final stop", {24'd0, led}, 32'h0);
    chk("final ready", {31'd0, cmd_ready}, 32'h1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
